// File: rtl/reg_pkg.sv
// Shared types and default geometry for the addressable register file.
package reg_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_word.sv
// Single loadable storage word with asynchronous active-low clear and a
// complemented copy of its contents.
module reg_word
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] out_compl_o
);

  logic [WIDTH-1:0] val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else if (load_i) begin
      val_q <= d_i;
    end
  end

  assign out_o       = val_q;
  assign out_compl_o = ~val_q;

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one write port, two registered read ports and a
// word-per-cycle clear sequencer. Define REG_FILE_BYPASS_EN for write-through reads.
module reg_file
  import reg_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_a_compl,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] rdata_b_compl,
  input  logic             clr,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wr_ok;
  logic [WIDTH-1:0] word_val   [DEPTH];
  logic [WIDTH-1:0] word_compl [DEPTH];
  logic [WIDTH-1:0] rdata_a_d, rdata_b_d;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  assign busy = (state_q == CLEAR);
  // A clear request wins over a write issued in the same idle cycle.
  assign wr_ok = we && (state_q == IDLE) && !clr && in_range(waddr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic clr_hit;
    logic load;

    assign clr_hit = busy && (cnt_q == AW'(i));
    assign load    = clr_hit || (wr_ok && (waddr == AW'(i)));

    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .d_i         (clr_hit ? '0 : wdata),
      .out_o       (word_val[i]),
      .out_compl_o (word_compl[i])
    );

    // Storage words must always present an exact complement pair.
    always_comb begin
      assert (word_compl[i] == ~word_val[i]);
    end
  end

  always_comb begin
    rdata_a_d = '0;
    if (in_range(raddr_a)) begin
      rdata_a_d = word_val[raddr_a];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (raddr_a == waddr)) begin
        rdata_a_d = wdata;
      end
`endif
    end
  end

  always_comb begin
    rdata_b_d = '0;
    if (in_range(raddr_b)) begin
      rdata_b_d = word_val[raddr_b];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (raddr_b == waddr)) begin
        rdata_b_d = wdata;
      end
`endif
    end
  end

  reg_word #(.WIDTH(WIDTH)) u_rd_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (re_a),
    .d_i         (rdata_a_d),
    .out_o       (rdata_a),
    .out_compl_o (rdata_a_compl)
  );

  reg_word #(.WIDTH(WIDTH)) u_rd_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (re_b),
    .d_i         (rdata_b_d),
    .out_o       (rdata_b),
    .out_compl_o (rdata_b_compl)
  );

endmodule

// File: tb/tb_reg_file.sv
// Randomised self-checking bench: an 8-word and a 6-word register file share
// all inputs and are compared each cycle against an array-based reference model.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        re_a, re_b;
  logic [2:0]  raddr_a, raddr_b;
  logic        clr;

  logic [15:0] rdA [2];
  logic [15:0] rdAc[2];
  logic [15:0] rdB [2];
  logic [15:0] rdBc[2];
  logic        busyO[2];

  logic [15:0] mem [2][8];
  int          depth [2];
  int          clrPos[2];
  logic [15:0] expA[2];
  logic [15:0] expB[2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file u_dut8 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdA[0]), .rdata_a_compl(rdAc[0]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdB[0]), .rdata_b_compl(rdBc[0]),
    .clr(clr), .busy(busyO[0])
  );

  reg_file #(.WIDTH(16), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdA[1]), .rdata_a_compl(rdAc[1]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdB[1]), .rdata_b_compl(rdBc[1]),
    .clr(clr), .busy(busyO[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = 16'h0000;
      clrPos[k] = -1;
      expA[k]   = 16'h0000;
      expB[k]   = 16'h0000;
    end
  endtask

  // Reads see the pre-edge contents (or forwarded data), then the edge's write/clear lands.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      bit acc;
      acc = (clrPos[k] < 0) && !clr && we && (int'(waddr) < depth[k]);
      if (re_a) begin
        if (int'(raddr_a) >= depth[k]) expA[k] = 16'h0000;
        else if (BYP && acc && raddr_a == waddr) expA[k] = wdata;
        else expA[k] = mem[k][raddr_a];
      end
      if (re_b) begin
        if (int'(raddr_b) >= depth[k]) expB[k] = 16'h0000;
        else if (BYP && acc && raddr_b == waddr) expB[k] = wdata;
        else expB[k] = mem[k][raddr_b];
      end
      if (clrPos[k] >= 0) begin
        mem[k][clrPos[k]] = 16'h0000;
        clrPos[k]++;
        if (clrPos[k] == depth[k]) clrPos[k] = -1;
      end else if (clr) begin
        clrPos[k] = 0;
      end else if (acc) begin
        mem[k][waddr] = wdata;
      end
    end
  endtask

  task automatic checkDuts(input string ctx);
    for (int k = 0; k < 2; k++) begin
      logic [15:0] ca, cb;
      ca = ~expA[k];
      cb = ~expB[k];
      checkOutput($sformatf("%s d%0d rdata_a", ctx, depth[k]), rdA[k], expA[k]);
      checkOutput($sformatf("%s d%0d rdata_a_compl", ctx, depth[k]), rdAc[k], ca);
      checkOutput($sformatf("%s d%0d rdata_b", ctx, depth[k]), rdB[k], expB[k]);
      checkOutput($sformatf("%s d%0d rdata_b_compl", ctx, depth[k]), rdBc[k], cb);
      checkOutput($sformatf("%s d%0d busy", ctx, depth[k]), busyO[k], clrPos[k] >= 0);
    end
  endtask

  task automatic applyStimulus(input bit iWe, input int iWaddr, input logic [15:0] iWdata,
                               input bit iReA, input int iRa, input bit iReB, input int iRb,
                               input bit iClr, input string ctx);
    we      = iWe;
    waddr   = 3'(iWaddr);
    wdata   = iWdata;
    re_a    = iReA;
    raddr_a = 3'(iRa);
    re_b    = iReB;
    raddr_b = 3'(iRb);
    clr     = iClr;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkDuts(ctx);
  endtask

  initial begin
    int busyCnt;
    depth[0] = 8;
    depth[1] = 6;
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clr = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkDuts("in reset");
    rst_n = 1'b1;
    applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0, "post reset");
    checkOutput("reset rdata_a literal", rdA[0], 16'h0000);
    checkOutput("reset rdata_a_compl literal", rdAc[0], 16'hFFFF);
    for (int a = 0; a < 8; a++) applyStimulus(0, 0, 16'h0, 1, a, 1, 7 - a, 0, "reset read");

    applyStimulus(1, 3, 16'hA5A5, 0, 0, 0, 0, 0, "write 3");
    applyStimulus(0, 0, 16'h0, 1, 3, 1, 3, 0, "read 3");
    checkOutput("read3 rdata_b literal", rdB[0], 16'hA5A5);
    checkOutput("read3 compl literal", rdBc[0], 16'h5A5A);

    applyStimulus(1, 5, 16'h1234, 1, 5, 1, 5, 0, "same-cycle raw");
    checkOutput("raw rdata_a literal", rdA[0], BYP ? 16'h1234 : 16'h0000);
    applyStimulus(0, 0, 16'h0, 1, 5, 0, 0, 0, "raw followup");
    checkOutput("raw followup literal", rdA[0], 16'h1234);

    for (int a = 0; a < 8; a++) applyStimulus(1, a, 16'hFFFF, 0, 0, 0, 0, 0, "fill");
    applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 1, "clr pulse");
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busyO[0]) break;
      busyCnt++;
      applyStimulus(i == 2, 0, 16'h7777, 1, i % 8, 1, (i + 3) % 8, 0, "clearing");
    end
    checkOutput("clear busy cycles d8", busyCnt, 8);
    for (int a = 0; a < 8; a++) applyStimulus(0, 0, 16'h0, 1, a, 1, a, 0, "after clear");
    checkOutput("dropped mid-clear write literal", rdA[0], 16'h0000);

    applyStimulus(1, 7, 16'hBEEF, 0, 0, 0, 0, 0, "write addr 7");
    applyStimulus(0, 0, 16'h0, 1, 7, 1, 5, 0, "read addr 7");
    checkOutput("d6 addr7 read literal", rdA[1], 16'h0000);
    for (int i = 0; i < 24; i++)
      applyStimulus(0, 0, 16'h0, 1, $urandom_range(0, 7), 1, $urandom_range(0, 7), 1, "clr held");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 16'h0, 1, i % 8, 0, 0, 0, "clr drain");

    for (int a = 0; a < 8; a++) applyStimulus(1, a, 16'(a * 16'h1111), 0, 0, 0, 0, 0, "refill");
    applyStimulus(0, 0, 16'h0, 1, 2, 1, 6, 1, "clr before reset");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 1, 7, 1, 4, 0, "clear to cycle 3");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkDuts("mid-clear reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 16'h0, 1, i % 8, 1, 7 - (i % 8), 0, "after abort");

    for (int i = 0; i < 400; i++) begin
      int wa;
      wa = $urandom_range(0, 7);
      applyStimulus($urandom_range(0, 1) == 1, wa, 16'($urandom),
                    $urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, 7),
                    $urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, 7),
                    $urandom_range(0, 29) == 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
